// File: rtl/ps2_keycode_pkg.sv
// -----------------------------------------------------------------------------
// ps2_keycode_pkg
// Shared types and constants for the PS/2 keyboard keycode block:
//   - receiver FSM state encoding
//   - internal key identifiers and held-mask bit positions
//   - PS/2 set-2 scancodes the decoder recognises
//   - output keycodes handed to the doodle motion block
//   - small helpers mapping between scancodes, keys, masks and output codes
// -----------------------------------------------------------------------------
package ps2_keycode_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'd0,
    KEY_A     = 2'd1,
    KEY_D     = 2'd2,
    KEY_SPACE = 2'd3
  } key_e;

  // Scancodes (set 2)
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  // Output keycodes
  localparam logic [7:0] KC_LEFT  = 8'h04;
  localparam logic [7:0] KC_RIGHT = 8'h07;
  localparam logic [7:0] KC_JUMP  = 8'h1C;
  localparam logic [7:0] KC_NONE  = 8'h00;

  // Held-mask layout
  localparam int HELD_W     = 3;
  localparam int HELD_A     = 0;
  localparam int HELD_D     = 1;
  localparam int HELD_SPACE = 2;

  function automatic key_e scan_to_key(input logic [7:0] sc);
    key_e k;
    case (sc)
      SC_A:     k = KEY_A;
      SC_D:     k = KEY_D;
      SC_SPACE: k = KEY_SPACE;
      default:  k = KEY_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [HELD_W-1:0] key_mask(input key_e k);
    logic [HELD_W-1:0] m;
    m = '0;
    case (k)
      KEY_A:     m[HELD_A]     = 1'b1;
      KEY_D:     m[HELD_D]     = 1'b1;
      KEY_SPACE: m[HELD_SPACE] = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] key_to_code(input key_e k);
    logic [7:0] c;
    case (k)
      KEY_A:     c = KC_LEFT;
      KEY_D:     c = KC_RIGHT;
      KEY_SPACE: c = KC_JUMP;
      default:   c = KC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_keycode_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 device-to-host frame receiver: 2-FF synchronizers on the raw PS/2 lines,
// falling-edge detect, 11-bit frame FSM (start, 8 data LSB first, odd parity,
// stop) and a mid-frame inactivity timeout.
//
// Ports
//   Clk           in   system clock (50 MHz)
//   Reset_n       in   asynchronous active-low reset
//   ps2_clk_i     in   raw PS/2 clock (asynchronous, idle high)
//   ps2_data_i    in   raw PS/2 data (asynchronous, idle high)
//   byte_o        out  last accepted byte (valid with byte_valid_o)
//   byte_valid_o  out  one-Clk pulse, the Clk after the stop-bit sample
//   err_o         out  one-Clk pulse on parity, stop-bit or timeout error
//
// state     | meaning
// ----------+--------------------------------------------------
// RX_IDLE   | waiting for a start bit (falling edge with data 0)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | sampling the odd-parity bit
// RX_STOP   | sampling the stop bit, accept or drop the byte
// -----------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_keycode_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Synchronizers idle high so release from reset never looks like an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= RX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_ok_q  <= 1'b0;
      tmo_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_ok_q  <= par_ok_d;
      tmo_q     <= tmo_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_ok_d  = par_ok_q;
    tmo_d     = tmo_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    // Inactivity timer: restarts on every edge; an edge in the terminal cycle
    // wins over the timeout.
    if (state_q == RX_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d   = '0;
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!data_sync_q) begin
            state_d   = RX_DATA;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = ^{data_sync_q, shift_q};
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (data_sync_q && par_ok_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_keycode.sv
// -----------------------------------------------------------------------------
// ps2_keycode
// Turns a PS/2 keyboard stream into a held-key code for the doodle motion
// block. Tracks break (F0) and extended (E0) prefixes, a held mask for A, D and
// space, and the most recently pressed key so the newest held key wins.
//
// Ports
//   Clk        in   system clock (50 MHz)
//   Reset_n    in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock (asynchronous, idle high)
//   ps2_data   in   raw PS/2 data (asynchronous, idle high)
//   keycode    out  8'h04 left, 8'h07 right, 8'h1C jump, 8'h00 none
//   key_event  out  one-Clk pulse when the held mask changes
//   frame_err  out  one-Clk pulse when a frame is dropped
// -----------------------------------------------------------------------------
module ps2_keycode
  import ps2_keycode_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .err_o        (rx_err)
  );

  logic              brk_q, brk_d;
  logic              ext_q, ext_d;
  logic [HELD_W-1:0] held_q, held_d;
  key_e              last_key_q, last_key_d;
  key_e              key_hit;
  logic              key_event_q, key_event_d;
  logic [7:0]        keycode_q, keycode_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      held_q      <= '0;
      last_key_q  <= KEY_NONE;
      key_event_q <= 1'b0;
      keycode_q   <= KC_NONE;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      held_q      <= held_d;
      last_key_q  <= last_key_d;
      key_event_q <= key_event_d;
      keycode_q   <= keycode_d;
    end
  end

  // Prefix/code decoder. Errored frames never raise rx_valid, so they leave
  // brk, ext and the held mask untouched.
  always_comb begin
    brk_d      = brk_q;
    ext_d      = ext_q;
    held_d     = held_q;
    last_key_d = last_key_q;
    key_hit    = KEY_NONE;

    if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) key_hit = scan_to_key(rx_byte);
        if (key_hit != KEY_NONE) begin
          if (brk_q) begin
            held_d = held_q & ~key_mask(key_hit);
          end else begin
            held_d     = held_q | key_mask(key_hit);
            last_key_d = key_hit;
          end
        end
      end
    end

    // Typematic repeats of a held key leave the mask unchanged: no event.
    key_event_d = (held_d != held_q);
  end

  // Output selection from registered state, so keycode trails the mask by one Clk.
  always_comb begin
    keycode_d = KC_NONE;
    if ((last_key_q != KEY_NONE) && ((held_q & key_mask(last_key_q)) != '0)) begin
      keycode_d = key_to_code(last_key_q);
    end else if (held_q[HELD_SPACE]) begin
      keycode_d = KC_JUMP;
    end else if (held_q[HELD_A]) begin
      keycode_d = KC_LEFT;
    end else if (held_q[HELD_D]) begin
      keycode_d = KC_RIGHT;
    end
  end

  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_keycode.sv
module tb_ps2_keycode;

  localparam int HALF = 20;            // PS/2 half bit time in Clk cycles
  localparam logic [1:0] EV_KEY = 2'b10;
  localparam logic [1:0] EV_ERR = 2'b01;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] kc;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic       kc_pending = 1'b0;
  logic [7:0] kc_exp = 8'h00;

  always #10 Clk = ~Clk;

  ps2_keycode dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every key_event / frame_err pulse pops one entry.
  always @(negedge Clk) begin
    exp_t e;
    if (kc_pending) begin
      check("keycode_after_event", keycode, kc_exp);
      kc_pending = 1'b0;
    end
    if (key_event || frame_err) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {key_event, frame_err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {key_event, frame_err}, e.kind);
        if (e.kind == EV_KEY) begin
          kc_pending = 1'b1;
          kc_exp     = e.kc;
        end else begin
          check("keycode_after_err", keycode, e.kc);
        end
      end
    end
  end

  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] kc);
    exp_t e;
    e.kind = kind;
    e.kc   = kc;
    exp_q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  // Drive the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || kc_pending) && n < budget) begin
      @(posedge Clk);
      n++;
    end
    check("scoreboard_drain", exp_q.size() + int'(kc_pending), 0);
    exp_q.delete();
    kc_pending = 1'b0;
    wait_clk(5);
  endtask

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_keycode", keycode, 8'h00);
    check("rst_key_event", key_event, 0);
    check("rst_frame_err", frame_err, 0);
    Reset_n = 1'b1;
    wait_clk(5);

    // Press A
    expect_evt(EV_KEY, 8'h04);
    send_byte(8'h1C);
    wait_drain(200);
    check("press_a", keycode, 8'h04);

    // Typematic repeat of A: no event, stable keycode
    send_byte(8'h1C);
    wait_drain(200);
    check("repeat_a", keycode, 8'h04);

    // Hold A, press then release space
    expect_evt(EV_KEY, 8'h1C);
    send_byte(8'h29);
    wait_drain(200);
    check("press_space", keycode, 8'h1C);
    send_byte(8'hF0);
    expect_evt(EV_KEY, 8'h04);
    send_byte(8'h29);
    wait_drain(200);
    check("release_space", keycode, 8'h04);

    // Bad parity on D: error only
    expect_evt(EV_ERR, 8'h04);
    send_bits(8'h23, 1'b1, 11);
    wait_drain(200);
    check("bad_parity_kc", keycode, 8'h04);

    // Bad stop bit (break prefix must not latch from the dropped frame)
    expect_evt(EV_ERR, 8'h04);
    begin
      logic [10:0] fr;
      fr = {1'b0, ~^8'hF0, 8'hF0, 1'b0};
      for (int i = 0; i < 11; i++) begin
        ps2_data = fr[i];
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_clk(HALF);
    end
    wait_drain(200);

    // Timeout after 4 data bits, then valid D
    expect_evt(EV_ERR, 8'h04);
    send_bits(8'h23, 1'b0, 5);
    wait_drain(6000);
    expect_evt(EV_KEY, 8'h07);
    send_byte(8'h23);
    wait_drain(200);
    check("press_d_after_tmo", keycode, 8'h07);

    // Release D -> A remains
    send_byte(8'hF0);
    expect_evt(EV_KEY, 8'h04);
    send_byte(8'h23);
    wait_drain(200);
    check("release_d", keycode, 8'h04);

    // Extended 1C ignored
    send_byte(8'hE0);
    send_byte(8'h1C);
    wait_drain(200);
    check("ext_ignored", keycode, 8'h04);

    // Release A -> nothing held
    send_byte(8'hF0);
    expect_evt(EV_KEY, 8'h00);
    send_byte(8'h1C);
    wait_drain(200);
    check("release_a", keycode, 8'h00);

    // Press space, then reset mid-frame
    expect_evt(EV_KEY, 8'h1C);
    send_byte(8'h29);
    wait_drain(200);
    check("space_before_rst", keycode, 8'h1C);
    send_bits(8'h23, 1'b0, 5);
    ps2_clk = 1'b0;
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_rst_keycode", keycode, 8'h00);
    check("async_rst_event", key_event, 0);
    wait_clk(4);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(2);
    Reset_n = 1'b1;
    wait_clk(5);
    check("post_rst_keycode", keycode, 8'h00);
    expect_evt(EV_KEY, 8'h07);
    send_byte(8'h23);
    wait_drain(200);
    check("post_rst_press_d", keycode, 8'h07);

    wait_clk(20);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
